dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory controller between the core's memory bus (load/store, funct3 type, byte address, store data) and a single-port, word-wide on-chip RAM with synchronous read.
- Converts byte, halfword and word accesses into word RAM cycles:
  - read-modify-write for sub-word stores;
  - sign/zero extension for loads.
- Raises stall until the access completes.
- Serves a repeated, identical request from a completed-request register, so a request the core holds across several FSM states executes exactly once.

Parameters:
- ADDR_BITS, 14, byte-address window size. Addresses with any of bits [31:ADDR_BITS] set are outside the window.
- WORD_AW, 12, RAM word-address width; equals ADDR_BITS-2.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_load  in  1  load request, level.
- req_store  in  1  store request, level; wins over req_load when both are high.
- req_type  in  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte or half is used for sub-word stores.
- rsp_rdata  out  32  extended load result; valid while stall=0 after a completed load.
- stall  out  1  high while the current request is incomplete.
- err  out  1  high while the current request is misaligned or has an illegal type.
- ram_addr  out  WORD_AW  RAM word address, req_addr[ADDR_BITS-1:2].
- ram_we  out  1  RAM write enable.
- ram_wdata  out  32  RAM write word.
- ram_rdata  in  32  RAM read word, valid one cycle after ram_addr is presented.

Behaviour:
- Active request:
  - active = (req_load | req_store) and req_addr[31:ADDR_BITS]==0.
  - op = store if req_store, else load.
- Completed-request register holds {valid, op, type, addr, wdata}.
  - hit = valid and every field equals the current request.
  - wdata is compared for stores only.
- FSM states: IDLE, RD, WR, DONE.
  - IDLE, active and not hit, legal request: stall=1 combinationally.
    - Load or sub-word store: go to RD.
    - Word store: go to WR.
  - RD: stall=1.
    - Load: extract from ram_rdata, latch into rdata_q, update the completed register, go to DONE.
    - Sub-word store: latch the merged word, go to WR.
  - WR: stall=1, ram_we=1, ram_wdata = merged word (or req_wdata for a word store). Update the completed register, go to DONE.
  - DONE: stall=0, go to IDLE next cycle.
  - IDLE, hit: stall=0, no RAM access.
  - IDLE, not active: stall=0, rsp_rdata=0.
- Latency, with the request presented at cycle N:
  - Load: stall=0 and rsp_rdata valid at N+2.
  - Word store: RAM written at N+1; stall=0 at N+2.
  - Sub-word store: RAM written at N+2; stall=0 at N+3.
- Byte lane selection:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Merge replaces only the selected lane of ram_rdata.
- Load extension:
  - B and H sign-extend from bit 7 and bit 15.
  - BU and HU zero-extend.
  - W passes the word through.
- Illegal requests: half with addr[0]=1; word with addr[1:0]!=0; load type 011, 110 or 111; store type other than 000–010.
  - err=1 and stall=0 combinationally.
  - No RAM access, rsp_rdata=0, completed register unchanged.
- rsp_rdata = rdata_q whenever hit or in DONE with op=load; otherwise 0.
- Invalidation:
  - Any store completion overwrites the completed register, so a later load to the same word re-reads RAM.
  - A request change while in RD or WR is ignored. The in-flight operation completes with its latched address, op, type and data.
- Reset (asynchronous, any state, including mid-RMW):
  - state=IDLE, valid=0, rdata_q=0.
  - ram_we=0, stall=0, err=0.
  - A partially completed store is abandoned; no RAM write occurs after rst_n falls.

Test Plan:
- LW at 0x0010 with RAM word 4 = 0x8899AABB → stall high for 2 cycles; then rsp_rdata=0x8899AABB and stall=0. Holding the request 3 more cycles → no further RAM read, stall stays 0.
- LB at 0x0013 and LBU at 0x0013, same word → rsp_rdata=0xFFFFFF88 and 0x00000088 respectively.
- SB 0x5A at 0x0011, then LW 0x0010 → one RAM write of 0x88995ABB in the 3rd request cycle; the load returns 0x88995ABB.
- SW 0x12345678 at 0x3FFC → ram_we pulses once at word 0xFFF; holding the request for 4 cycles produces no second write.
- LH at 0x0013 → err=1, stall=0, no RAM access. LW at 0x4000 → stall=0, err=0, rsp_rdata=0, ram_we=0.
- SH in progress; rst_n low during RD → next edge state IDLE, ram_we never asserted, RAM unchanged.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Core-side data-memory bus: request fields from the core, response and
// stall/err status from the controller.
`timescale 1ns/1ps
interface dmem_ctrl_if;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rsp_rdata;
  logic        stall;
  logic        err;

  // Core side drives requests and observes the response.
  modport master (
    output req_load, req_store, req_type, req_addr, req_wdata,
    input  rsp_rdata, stall, err
  );

  // Controller side observes requests and drives the response.
  modport slave (
    input  req_load, req_store, req_type, req_addr, req_wdata,
    output rsp_rdata, stall, err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns byte/half/word loads and stores from the core
// into word-wide cycles on a single-port synchronous-read RAM. Sub-word stores
// use read-modify-write; loads are sign/zero extended. A repeated identical
// request is answered from the completed-request register without touching RAM.
`timescale 1ns/1ps
module dmem_ctrl #(
  parameter int ADDR_BITS = 14,
  parameter int WORD_AW   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_ctrl_if.slave         bus,
  output logic [WORD_AW-1:0] ram_addr,
  output logic               ram_we,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  // Legal type for the operation and naturally aligned address.
  function automatic logic req_legal(input logic st, input logic [2:0] t,
                                     input logic [1:0] lane);
    logic ok;
    case (t)
      T_B:     ok = 1'b1;
      T_H:     ok = !lane[0];
      T_W:     ok = (lane == 2'b00);
      T_BU:    ok = !st;
      T_HU:    ok = !st && !lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Pick the addressed lane of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [2:0] t,
                                              input logic [1:0] lane,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (t)
      T_B:     r = {{24{b[7]}}, b};
      T_BU:    r = {24'h0, b};
      T_H:     r = {{16{h[15]}}, h};
      T_HU:    r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the selected byte/half lane of the old word with store data.
  function automatic logic [31:0] merge_word(input logic [2:0] t,
                                             input logic [1:0] lane,
                                             input logic [31:0] old_w,
                                             input logic [31:0] new_w);
    logic [31:0] mask;
    logic [31:0] ins;
    case (t)
      T_B: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        ins  = {24'h0, new_w[7:0]} << {lane, 3'b000};
      end
      T_H: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        ins  = {16'h0, new_w[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ins  = new_w;
      end
    endcase
    return (old_w & ~mask) | ins;
  endfunction

  // The in-flight latches double as the completed-request register: they are
  // loaded when an access starts (valid cleared) and marked valid when it
  // finishes, so they always describe the last completed access while idle.
  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        op_q, op_d;           // 1 = store
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;

  logic active;
  logic legal;
  logic hit;
  logic start;
  logic stall_c;

  assign active = (bus.req_load | bus.req_store) &&
                  ((bus.req_addr >> ADDR_BITS) == 32'd0);
  assign legal  = req_legal(bus.req_store, bus.req_type, bus.req_addr[1:0]);
  assign hit    = valid_q && active &&
                  (op_q == bus.req_store) &&
                  (type_q == bus.req_type) &&
                  (addr_q == bus.req_addr) &&
                  (!bus.req_store || (wdata_q == bus.req_wdata));
  assign start  = (state_q == S_IDLE) && active && legal && !hit;

  // Next-state and datapath latches for the access sequencer.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    op_d        = op_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          valid_d = 1'b0;
          op_d    = bus.req_store;
          type_d  = bus.req_type;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (bus.req_store && (bus.req_type == T_W)) begin
            ram_we_d    = 1'b1;
            ram_wdata_d = bus.req_wdata;
            state_d     = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (!op_q) begin
          rdata_d = load_extend(type_q, addr_q[1:0], ram_rdata);
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          ram_wdata_d = merge_word(type_q, addr_q[1:0], ram_rdata, wdata_q);
          ram_we_d    = 1'b1;
          state_d     = S_WR;
        end
      end
      S_WR: begin
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered RAM write controls; reset abandons any RMW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      op_q        <= 1'b0;
      type_q      <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      op_q        <= op_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Stall while a startable request waits in IDLE or an access is in flight.
  always_comb begin
    stall_c = 1'b0;
    case (state_q)
      S_IDLE:  stall_c = active && legal && !hit;
      S_RD:    stall_c = 1'b1;
      S_WR:    stall_c = 1'b1;
      default: stall_c = 1'b0;
    endcase
  end

  // RAM sees the live request address in IDLE so the read starts immediately.
  assign ram_addr  = (state_q == S_IDLE) ? bus.req_addr[ADDR_BITS-1:2]
                                         : addr_q[ADDR_BITS-1:2];
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

  // Status outputs are forced quiet while reset is asserted.
  assign bus.stall     = rst_n & stall_c;
  assign bus.err       = rst_n & (state_q == S_IDLE) & active & !legal;
  assign bus.rsp_rdata = (hit || ((state_q == S_DONE) && !op_q)) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a directed vector table, hand-written hold and reset
// sequences, then randomized requests checked against a behavioural model.
`timescale 1ns/1ps
module tb_dmem_ctrl;
  localparam int AB = 14;
  localparam int WA = 12;
  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_ctrl_if bus ();
  logic [WA-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  dmem_ctrl #(.ADDR_BITS(AB), .WORD_AW(WA)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Initial RAM contents: word 4 holds the directed test value.
  function automatic logic [31:0] pat(input int i);
    if (i == 4) return 32'h8899AABB;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Synchronous-read RAM; unwritten words read as the pattern.
  logic [31:0]  mem [4096];
  bit           written [4096];
  int unsigned  wr_cnt = 0;
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
      wr_cnt            <= wr_cnt + 1;
    end
    ram_rdata <= written[ram_addr] ? mem[ram_addr] : pat(int'(ram_addr));
  end

  function automatic logic [31:0] mem_word(input int i);
    return written[i] ? mem[i] : pat(i);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // Present one request after a rising edge and wait (bounded) for stall=0.
  task automatic run_req(input logic st, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, output int cyc, output logic [31:0] rd,
                         output logic er, output int unsigned wr);
    int unsigned w0;
    @(posedge clk);
    #1;
    bus.req_load  = !st;
    bus.req_store = st;
    bus.req_type  = t;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    w0  = wr_cnt;
    cyc = 0;
    @(negedge clk);
    while (bus.stall && cyc < 10) begin
      cyc++;
      @(negedge clk);
    end
    rd = bus.rsp_rdata;
    er = bus.err;
    wr = wr_cnt - w0;
    $display("req st=%0d type=%0d addr=%08h wdata=%08h -> cycles=%0d rdata=%08h err=%0d writes=%0d",
             st, t, a, wd, cyc, rd, er, wr);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] wd;
    int          cyc;
    logic        er;
    logic        chk_rd;
    logic [31:0] rd;
    int unsigned wr;
  } vec_t;

  vec_t tbl [21];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc;
    logic [31:0] rd;
    logic        er;
    int unsigned wr;
    int unsigned w0;
    // random-phase model state
    logic        st;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] ref_mem [int];
    logic        m_valid;
    logic        m_st;
    logic [2:0]  m_t;
    logic [31:0] m_a;
    logic [31:0] m_wd;
    logic [31:0] m_rd;

    bus.req_load  = 1'b0;
    bus.req_store = 1'b0;
    bus.req_type  = 3'b000;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;

    //                 st    type  addr         wdata        cyc err  chk  rdata         wr
    tbl[0]  = '{1'b0, T_W,  32'h0010, 32'h0,        2, 1'b0, 1'b1, 32'h8899AABB, 0};
    tbl[1]  = '{1'b0, T_W,  32'h0010, 32'h0,        0, 1'b0, 1'b1, 32'h8899AABB, 0};
    tbl[2]  = '{1'b0, T_B,  32'h0013, 32'h0,        2, 1'b0, 1'b1, 32'hFFFFFF88, 0};
    tbl[3]  = '{1'b0, T_BU, 32'h0013, 32'h0,        2, 1'b0, 1'b1, 32'h00000088, 0};
    tbl[4]  = '{1'b1, T_B,  32'h0011, 32'h0000005A, 3, 1'b0, 1'b0, 32'h0,        1};
    tbl[5]  = '{1'b0, T_W,  32'h0010, 32'h0,        2, 1'b0, 1'b1, 32'h88995ABB, 0};
    tbl[6]  = '{1'b1, T_W,  32'h3FFC, 32'h12345678, 2, 1'b0, 1'b0, 32'h0,        1};
    tbl[7]  = '{1'b1, T_W,  32'h3FFC, 32'h12345678, 0, 1'b0, 1'b0, 32'h0,        0};
    tbl[8]  = '{1'b0, T_H,  32'h0013, 32'h0,        0, 1'b1, 1'b1, 32'h0,        0};
    tbl[9]  = '{1'b0, T_W,  32'h4000, 32'h0,        0, 1'b0, 1'b1, 32'h0,        0};
    tbl[10] = '{1'b0, T_W,  32'h3FFC, 32'h0,        2, 1'b0, 1'b1, 32'h12345678, 0};
    tbl[11] = '{1'b0, T_H,  32'h3FFE, 32'h0,        2, 1'b0, 1'b1, 32'h00001234, 0};
    tbl[12] = '{1'b0, T_HU, 32'h3FFC, 32'h0,        2, 1'b0, 1'b1, 32'h00005678, 0};
    tbl[13] = '{1'b0, T_H,  32'h0012, 32'h0,        2, 1'b0, 1'b1, 32'hFFFF8899, 0};
    tbl[14] = '{1'b1, T_H,  32'h0012, 32'hFFFFBEEF, 3, 1'b0, 1'b0, 32'h0,        1};
    tbl[15] = '{1'b0, T_W,  32'h0010, 32'h0,        2, 1'b0, 1'b1, 32'hBEEF5ABB, 0};
    tbl[16] = '{1'b1, 3'b011, 32'h0010, 32'h1,      0, 1'b1, 1'b1, 32'h0,        0};
    tbl[17] = '{1'b0, 3'b110, 32'h0010, 32'h0,      0, 1'b1, 1'b1, 32'h0,        0};
    tbl[18] = '{1'b0, T_W,  32'h0012, 32'h0,        0, 1'b1, 1'b1, 32'h0,        0};
    tbl[19] = '{1'b0, T_BU, 32'h0011, 32'h0,        2, 1'b0, 1'b1, 32'h0000005A, 0};
    tbl[20] = '{1'b0, T_B,  32'h0010, 32'h0,        2, 1'b0, 1'b1, 32'hFFFFFFBB, 0};

    // Reset state
    @(negedge clk);
    chk("reset_stall", bus.stall, 1'b0);
    chk("reset_err", bus.err, 1'b0);
    chk("reset_we", ram_we, 1'b0);
    chk("reset_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 21; i++) begin
      run_req(tbl[i].st, tbl[i].t, tbl[i].a, tbl[i].wd, cyc, rd, er, wr);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
      chk($sformatf("vec%0d_err", i), er, tbl[i].er);
      chk($sformatf("vec%0d_writes", i), 32'(wr), 32'(tbl[i].wr));
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
    end
    chk("ram_word4", mem_word(4), 32'hBEEF5ABB);
    chk("ram_wordfff", mem_word(12'hFFF), 32'h12345678);

    // Held load: executes once, then stays served without stall or writes
    run_req(1'b0, T_W, 32'h3FFC, 32'h0, cyc, rd, er, wr);
    chk("hold_first_cycles", 32'(cyc), 32'd2);
    chk("hold_first_rdata", rd, 32'h12345678);
    w0 = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_stall", k), bus.stall, 1'b0);
      chk($sformatf("hold%0d_rdata", k), bus.rsp_rdata, 32'h12345678);
    end
    chk("hold_writes", 32'(wr_cnt - w0), 32'd0);

    // Reset during the read phase of a halfword RMW
    @(posedge clk);
    #1;
    bus.req_load  = 1'b0;
    bus.req_store = 1'b1;
    bus.req_type  = T_H;
    bus.req_addr  = 32'h0020;
    bus.req_wdata = 32'h0000CAFE;
    w0 = wr_cnt;
    @(negedge clk);
    chk("rmw_start_stall", bus.stall, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_stall", bus.stall, 1'b0);
    chk("rmw_rst_err", bus.err, 1'b0);
    chk("rmw_rst_we", ram_we, 1'b0);
    bus.req_store = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rmw_rst_writes", 32'(wr_cnt - w0), 32'd0);
    chk("rmw_rst_ram", mem_word(8), pat(8));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", bus.stall, 1'b0);
    chk("post_rst_rdata", bus.rsp_rdata, 32'h0);
    // Completed register was cleared, so the same load re-reads RAM
    run_req(1'b0, T_W, 32'h3FFC, 32'h0, cyc, rd, er, wr);
    chk("post_rst_reload_cycles", 32'(cyc), 32'd2);
    chk("post_rst_reload_rdata", rd, 32'h12345678);

    // Randomized requests against a behavioural model (words 0x40..0x7F)
    m_valid = 1'b0;
    m_st = 1'b0; m_t = 3'b0; m_a = 32'h0; m_wd = 32'h0; m_rd = 32'h0;
    st = 1'b0; t = 3'b0; a = 32'h0; wd = 32'h0;
    for (int it = 0; it < 200; it++) begin
      int          tt;
      int          sz;
      int          off;
      int          w;
      bit          active;
      bit          legal;
      bit          hit;
      logic [31:0] word;
      logic [31:0] mask;
      logic [31:0] exp_rd;
      if (it == 0 || $urandom_range(0, 3) != 0) begin
        st = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) begin
          t = 3'($urandom_range(0, 7));
        end else begin
          tt = $urandom_range(0, 4);
          t  = 3'((tt < 3) ? tt : tt + 1);
        end
        a = 32'h100 + 32'($urandom_range(0, 255));
        if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(14, 31));
        wd = $urandom;
      end
      run_req(st, t, a, wd, cyc, rd, er, wr);

      tt     = int'(t);
      sz     = ((tt % 4) == 0) ? 1 : (((tt % 4) == 1) ? 2 : 4);
      active = (a < 32'd16384);
      legal  = (st ? (tt <= 2) : (tt != 3 && tt <= 5)) && ((a % sz) == 0);
      hit    = m_valid && m_st == st && m_t == t && m_a == a && (!st || m_wd == wd);
      off    = int'(a % 4);
      w      = int'((a % 16384) / 4);
      word   = ref_mem.exists(w) ? ref_mem[w] : pat(w);
      mask   = (sz == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * sz)) - 1);

      if (!active || !legal) begin
        chk($sformatf("rnd%0d_cycles", it), 32'(cyc), 32'd0);
        chk($sformatf("rnd%0d_err", it), er, (active && !legal));
        chk($sformatf("rnd%0d_rdata", it), rd, 32'h0);
        chk($sformatf("rnd%0d_writes", it), 32'(wr), 32'd0);
      end else if (hit) begin
        chk($sformatf("rnd%0d_cycles", it), 32'(cyc), 32'd0);
        chk($sformatf("rnd%0d_err", it), er, 1'b0);
        chk($sformatf("rnd%0d_writes", it), 32'(wr), 32'd0);
        if (!st) chk($sformatf("rnd%0d_rdata", it), rd, m_rd);
      end else if (!st) begin
        exp_rd = (word >> (8 * off)) & mask;
        if (tt < 4 && sz < 4 && exp_rd[8 * sz - 1]) exp_rd = exp_rd | ~mask;
        chk($sformatf("rnd%0d_cycles", it), 32'(cyc), 32'd2);
        chk($sformatf("rnd%0d_err", it), er, 1'b0);
        chk($sformatf("rnd%0d_rdata", it), rd, exp_rd);
        chk($sformatf("rnd%0d_writes", it), 32'(wr), 32'd0);
        m_valid = 1'b1; m_st = st; m_t = t; m_a = a; m_wd = wd; m_rd = exp_rd;
      end else begin
        word = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        ref_mem[w] = word;
        chk($sformatf("rnd%0d_cycles", it), 32'(cyc), (sz == 4) ? 32'd2 : 32'd3);
        chk($sformatf("rnd%0d_err", it), er, 1'b0);
        chk($sformatf("rnd%0d_writes", it), 32'(wr), 32'd1);
        chk($sformatf("rnd%0d_ram", it), mem_word(w), word);
        m_valid = 1'b1; m_st = st; m_t = t; m_a = a; m_wd = wd;
      end
    end

    bus.req_load  = 1'b0;
    bus.req_store = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
